// File: rtl/decode_issue_buffer.sv
// Fetch-to-decode register for an ISSUE_WIDTH-wide bundle. A bundle with
// intra-bundle RAW hazards issues as several independent groups while fetch is held.
module decode_issue_buffer #(
  parameter int ISSUE_WIDTH = 2,
  parameter int PC_W        = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic [32*ISSUE_WIDTH-1:0] instr_f_i,
  input  logic [PC_W-1:0]           pcplus4_f_i,
  input  logic [ISSUE_WIDTH-1:0]    pred_f_i,
  output logic                      fetch_ready_o,
  output logic [32*ISSUE_WIDTH-1:0] instr_d_o,
  output logic [ISSUE_WIDTH-1:0]    valid_d_o,
  output logic [PC_W-1:0]           pcplus4_d_o,
  output logic [ISSUE_WIDTH-1:0]    pred_d_o,
  output logic                      split_o
);

  localparam logic [0:0] NORMAL = 1'b0;
  localparam logic [0:0] SPLIT  = 1'b1;
  localparam logic [2:0] LAST   = 3'(ISSUE_WIDTH);

  logic [0:0]               state;
  logic [32*ISSUE_WIDTH-1:0] bundleHeld;
  logic [2:0]               startSlot;

  logic [32*ISSUE_WIDTH-1:0] srcBundle;
  logic [2:0]               srcStart;
  logic [2:0]               groupEnd;
  logic [ISSUE_WIDTH-1:0]   groupMask;
  logic [32*ISSUE_WIDTH-1:0] groupInstr;
  logic [5:0]               opS  [ISSUE_WIDTH];
  logic [4:0]               rsS  [ISSUE_WIDTH];
  logic [4:0]               rtS  [ISSUE_WIDTH];
  logic [4:0]               rdS  [ISSUE_WIDTH];
  logic [4:0]               dstS [ISSUE_WIDTH];

  function automatic logic [4:0] dstReg(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rd);
    case (op)
      6'h00:                                   return rd;
      6'h23, 6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h0f: return rt;
      default:                                 return 5'd0;
    endcase
  endfunction

  function automatic logic readsReg(input logic [5:0] op, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] r);
    logic rsUsed;
    logic rtUsed;
    rsUsed = !(op == 6'h02 || op == 6'h03 || op == 6'h0f);
    rtUsed = (op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2b);
    return (rsUsed && rs == r) || (rtUsed && rt == r);
  endfunction

  assign fetch_ready_o = (state == NORMAL) && !stall_i;

  // Group formation: in SPLIT the held bundle continues from the stored start slot.
  always_comb begin
    srcBundle  = (state == SPLIT) ? bundleHeld : instr_f_i;
    srcStart   = (state == SPLIT) ? startSlot : 3'd0;
    groupEnd   = LAST;
    groupMask  = '0;
    groupInstr = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      opS[i]  = srcBundle[32*i+26 +: 6];
      rsS[i]  = srcBundle[32*i+21 +: 5];
      rtS[i]  = srcBundle[32*i+16 +: 5];
      rdS[i]  = srcBundle[32*i+11 +: 5];
      dstS[i] = dstReg(opS[i], rtS[i], rdS[i]);
    end
    // The first dependent slot above the start closes the group; $0 never conflicts.
    for (int j = 1; j < ISSUE_WIDTH; j++) begin
      for (int i = 0; i < ISSUE_WIDTH - 1; i++) begin
        if (groupEnd == LAST && i < j && 3'(i) >= srcStart && 3'(j) > srcStart &&
            dstS[i] != 5'd0 && readsReg(opS[j], rsS[j], rtS[j], dstS[i]))
          groupEnd = 3'(j);
      end
    end
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      groupMask[i] = (3'(i) >= srcStart) && (3'(i) < groupEnd);
      groupInstr[32*i +: 32] = groupMask[i] ? srcBundle[32*i +: 32] : 32'd0;
    end
  end

  // Decode-stage register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= NORMAL;
      startSlot   <= 3'd0;
      bundleHeld  <= '0;
      instr_d_o   <= '0;
      valid_d_o   <= '0;
      pcplus4_d_o <= '0;
      pred_d_o    <= '0;
      split_o     <= 1'b0;
    end else if (!stall_i) begin
      if (flush_i) begin
        state       <= NORMAL;
        startSlot   <= 3'd0;
        bundleHeld  <= '0;
        instr_d_o   <= '0;
        valid_d_o   <= '0;
        pcplus4_d_o <= '0;
        pred_d_o    <= '0;
        split_o     <= 1'b0;
      end else begin
        instr_d_o <= groupInstr;
        valid_d_o <= groupMask;
        split_o   <= (state == SPLIT);
        if (state == NORMAL) begin
          bundleHeld  <= instr_f_i;
          pcplus4_d_o <= pcplus4_f_i;
          pred_d_o    <= pred_f_i;
        end
        if (groupEnd < LAST) begin
          startSlot <= groupEnd;
          state     <= SPLIT;
        end else begin
          startSlot <= 3'd0;
          state     <= NORMAL;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Bench for decode_issue_buffer: 2-wide and 4-wide instances against a group-list
// reference model, plus directed bundles with hand-derived expectations.
module tb_decode_issue_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, stall, flush;
  logic [31:0]  pc;
  logic [63:0]  instr2;
  logic [1:0]   pred2;
  logic [127:0] instr4;
  logic [3:0]   pred4;

  logic         rdy2, split2, rdy4, split4;
  logic [63:0]  instrD2;
  logic [1:0]   valid2, predD2;
  logic [31:0]  pcD2, pcD4;
  logic [127:0] instrD4;
  logic [3:0]   valid4, predD4;

  int vectors = 0;
  int errors  = 0;
  bit checkEn = 0;

  decode_issue_buffer #(.ISSUE_WIDTH(2), .PC_W(32)) dut2 (
    .clk(clk), .reset(reset), .stall_i(stall), .flush_i(flush),
    .instr_f_i(instr2), .pcplus4_f_i(pc), .pred_f_i(pred2),
    .fetch_ready_o(rdy2), .instr_d_o(instrD2), .valid_d_o(valid2),
    .pcplus4_d_o(pcD2), .pred_d_o(predD2), .split_o(split2));

  decode_issue_buffer #(.ISSUE_WIDTH(4), .PC_W(32)) dut4 (
    .clk(clk), .reset(reset), .stall_i(stall), .flush_i(flush),
    .instr_f_i(instr4), .pcplus4_f_i(pc), .pred_f_i(pred4),
    .fetch_ready_o(rdy4), .instr_d_o(instrD4), .valid_d_o(valid4),
    .pcplus4_d_o(pcD4), .pred_d_o(predD4), .split_o(split4));

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [4:0] writes(input logic [31:0] x);
    case (x[31:26])
      6'h00:                                   return x[15:11];
      6'h23, 6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h0f: return x[20:16];
      default:                                 return 5'd0;
    endcase
  endfunction

  function automatic bit reads(input logic [31:0] x, input logic [4:0] r);
    bit rsRead, rtRead;
    rsRead = !(x[31:26] inside {6'h02, 6'h03, 6'h0f});
    rtRead = x[31:26] inside {6'h00, 6'h04, 6'h05, 6'h2b};
    return (rsRead && x[25:21] == r) || (rtRead && x[20:16] == r);
  endfunction

  // Splits a whole bundle into its ordered list of issue masks (4 bits each).
  task automatic plan(input int w, input logic [127:0] b, output logic [15:0] masks,
                      output int cnt);
    int s, k;
    bit hit;
    logic [4:0] r;
    masks = '0;
    cnt = 0;
    s = 0;
    while (s < w) begin
      k = w;
      hit = 0;
      for (int j = s + 1; j < w && !hit; j++)
        for (int i = s; i < j && !hit; i++) begin
          r = writes(b[32*i +: 32]);
          if (r != 5'd0 && reads(b[32*j +: 32], r)) begin
            k = j;
            hit = 1;
          end
        end
      for (int i = s; i < k; i++) masks[4*cnt + i] = 1'b1;
      cnt++;
      s = k;
    end
  endtask

  logic [127:0] mBundle[2];
  logic [15:0]  mList[2];
  int           mCnt[2], mHead[2];
  logic [127:0] eInstr[2];
  logic [3:0]   eValid[2], ePred[2];
  logic [31:0]  ePc[2];
  logic         eSplit[2];

  task automatic issue(input int d, input logic [3:0] m);
    eValid[d] = m;
    for (int i = 0; i < 4; i++)
      eInstr[d][32*i +: 32] = m[i] ? mBundle[d][32*i +: 32] : 32'd0;
  endtask

  task automatic modelClear(input int d);
    mHead[d] = 0; mCnt[d] = 0; mBundle[d] = '0; mList[d] = '0;
    eInstr[d] = '0; eValid[d] = '0; ePred[d] = '0; ePc[d] = '0; eSplit[d] = 1'b0;
  endtask

  task automatic modelStep(input int d, input int w, input logic [127:0] b, input logic [3:0] p);
    if (mHead[d] < mCnt[d]) begin
      issue(d, mList[d][4*mHead[d] +: 4]);
      eSplit[d] = 1'b1;
      mHead[d]++;
    end else begin
      mBundle[d] = b;
      plan(w, b, mList[d], mCnt[d]);
      issue(d, mList[d][3:0]);
      mHead[d] = 1;
      eSplit[d] = 1'b0;
      ePc[d] = pc;
      ePred[d] = p;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      modelClear(0);
      modelClear(1);
    end else if (!stall) begin
      if (flush) begin
        modelClear(0);
        modelClear(1);
      end else begin
        modelStep(0, 2, {64'd0, instr2}, {2'b00, pred2});
        modelStep(1, 4, instr4, pred4);
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (checkEn) begin
      check("w2.instr", {64'd0, instrD2}, eInstr[0]);
      check("w2.valid", 128'(valid2), 128'(eValid[0]));
      check("w2.pc",    128'(pcD2), 128'(ePc[0]));
      check("w2.pred",  128'(predD2), 128'(ePred[0]));
      check("w2.split", 128'(split2), 128'(eSplit[0]));
      check("w2.ready", 128'(rdy2), 128'(logic'(mHead[0] >= mCnt[0] && !stall)));
      check("w4.instr", instrD4, eInstr[1]);
      check("w4.valid", 128'(valid4), 128'(eValid[1]));
      check("w4.pc",    128'(pcD4), 128'(ePc[1]));
      check("w4.pred",  128'(predD4), 128'(ePred[1]));
      check("w4.split", 128'(split4), 128'(eSplit[1]));
      check("w4.ready", 128'(rdy4), 128'(logic'(mHead[1] >= mCnt[1] && !stall)));
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] ADD1 = 32'h00430820;  // add $1,$2,$3
  localparam logic [31:0] SUB4 = 32'h00252022;  // sub $4,$1,$5
  localparam logic [31:0] ADD0 = 32'h00430020;  // add $0,$2,$3
  localparam logic [31:0] SUB0 = 32'h00052022;  // sub $4,$0,$5
  localparam logic [31:0] ADDI = 32'h20860001;  // addi $6,$4,1

  task automatic edgeStep();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rndInstr();
    logic [5:0] op;
    case ($urandom_range(0, 7))
      0: op = 6'h00;  1: op = 6'h23;  2: op = 6'h08;  3: op = 6'h0f;
      4: op = 6'h04;  5: op = 6'h2b;  6: op = 6'h02;  default: op = 6'h0d;
    endcase
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 11'h020};
  endfunction

  logic [15:0] pm;
  int pc_cnt;

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; pc = '0;
    instr2 = '0; pred2 = '0; instr4 = '0; pred4 = '0;
    edgeStep();
    edgeStep();
    checkEn = 1;
    check("rst.valid2", 128'(valid2), 128'd0);
    check("rst.instr4", instrD4, 128'd0);
    check("rst.ready2", 128'(rdy2), 128'd1);
    reset = 1'b1;

    plan(4, {32'd0, ADDI, SUB4, ADD1}, pm, pc_cnt);
    check("model.plan4", 128'(pm), 128'h0c21);
    check("model.cnt4", 128'(pc_cnt), 128'd3);
    plan(2, {64'd0, SUB0, ADD0}, pm, pc_cnt);
    check("model.plan2nohaz", 128'(pm), 128'h0003);

    // Two-slot split
    instr2 = {SUB4, ADD1}; pc = 32'h1000; pred2 = 2'b10;
    edgeStep();
    instr2 = '0;
    check("a.valid1", 128'(valid2), 128'h1);
    check("a.instr1", 128'(instrD2), {64'd0, 32'd0, ADD1});
    check("a.split1", 128'(split2), 128'd0);
    check("a.ready1", 128'(rdy2), 128'd0);
    edgeStep();
    check("a.valid2", 128'(valid2), 128'h2);
    check("a.instr2", 128'(instrD2), {64'd0, SUB4, 32'd0});
    check("a.split2", 128'(split2), 128'd1);
    check("a.pc2", 128'(pcD2), 128'h1000);
    check("a.pred2", 128'(predD2), 128'h2);
    check("a.ready2", 128'(rdy2), 128'd1);

    // $0 destination is never a hazard
    instr2 = {SUB0, ADD0};
    edgeStep();
    instr2 = '0;
    check("b.valid", 128'(valid2), 128'h3);
    check("b.instr", 128'(instrD2), {64'd0, SUB0, ADD0});
    check("b.split", 128'(split2), 128'd0);

    // Four-slot bundle in three groups
    instr4 = {32'd0, ADDI, SUB4, ADD1}; pc = 32'h2000;
    edgeStep();
    instr4 = '0;
    check("c.valid1", 128'(valid4), 128'h1);
    check("c.ready1", 128'(rdy4), 128'd0);
    edgeStep();
    check("c.valid2", 128'(valid4), 128'h2);
    check("c.split2", 128'(split4), 128'd1);
    check("c.pc2", 128'(pcD4), 128'h2000);
    edgeStep();
    check("c.valid3", 128'(valid4), 128'hc);
    check("c.instr3", instrD4, {32'd0, ADDI, 64'd0});
    check("c.pc3", 128'(pcD4), 128'h2000);
    check("c.ready3", 128'(rdy4), 128'd1);

    // Flush during SPLIT
    instr2 = {SUB4, ADD1};
    edgeStep();
    instr2 = '0;
    check("d.valid0", 128'(valid2), 128'h1);
    flush = 1'b1;
    edgeStep();
    flush = 1'b0;
    check("d.valid", 128'(valid2), 128'd0);
    check("d.instr", 128'(instrD2), 128'd0);
    check("d.pc", 128'(pcD2), 128'd0);
    check("d.split", 128'(split2), 128'd0);
    check("d.ready", 128'(rdy2), 128'd1);

    // Stall during SPLIT
    instr2 = {SUB4, ADD1}; pc = 32'h3000;
    edgeStep();
    instr2 = '0;
    stall = 1'b1;
    repeat (3) begin
      edgeStep();
      check("e.validHeld", 128'(valid2), 128'h1);
      check("e.instrHeld", 128'(instrD2), {64'd0, 32'd0, ADD1});
      check("e.ready", 128'(rdy2), 128'd0);
    end
    stall = 1'b0;
    edgeStep();
    check("e.validRem", 128'(valid2), 128'h2);
    check("e.splitRem", 128'(split2), 128'd1);

    // Asynchronous reset mid-SPLIT
    instr2 = {SUB4, ADD1};
    edgeStep();
    instr2 = '0;
    #1 reset = 1'b0;
    #1;
    check("f.valid", 128'(valid2), 128'd0);
    check("f.instr", 128'(instrD2), 128'd0);
    check("f.split", 128'(split2), 128'd0);
    edgeStep();
    reset = 1'b1;
    instr2 = {SUB0, ADD0};
    #1;
    check("f.ready", 128'(rdy2), 128'd1);
    edgeStep();
    instr2 = '0;
    check("f.accept", 128'(valid2), 128'h3);

    // Randomized traffic
    repeat (3000) begin
      instr2 = {rndInstr(), rndInstr()};
      instr4 = {rndInstr(), rndInstr(), rndInstr(), rndInstr()};
      pc     = $urandom;
      pred2  = 2'($urandom);
      pred4  = 4'($urandom);
      stall  = ($urandom_range(0, 9) == 0);
      flush  = ($urandom_range(0, 19) == 0);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 199) == 0) reset = 1'b0;
      edgeStep();
    end
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    edgeStep();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
